// File: rtl/wb_regfile_hilo.sv
// Writeback-side GPR file and HI/LO pair.
// Commits MEM/WB writes on the edge and serves bypassed combinational reads.
module wb_regfile_hilo #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_wreg,
  input  logic [ADDR_W-1:0] wb_wd,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              wb_whilo,
  input  logic [DATA_W-1:0] wb_hi,
  input  logic [DATA_W-1:0] wb_lo,
  input  logic              re1,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic gpr_we;

  // Writes to $0 are dropped here so the entry stays zero in storage.
  assign gpr_we = wb_wreg && (wb_wd != '0);

  always_comb begin
    regs_d = regs_q;
    if (gpr_we) begin
      regs_d[wb_wd] = wb_wdata;
    end
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (wb_whilo) begin
      hi_d = wb_hi;
      lo_d = wb_lo;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  always_comb begin
    rdata1 = '0;
    if (rst || !re1 || (raddr1 == '0)) begin
      rdata1 = '0;
    end else if (wb_wreg && (raddr1 == wb_wd)) begin
      rdata1 = wb_wdata;
    end else begin
      rdata1 = regs_q[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if (rst || !re2 || (raddr2 == '0)) begin
      rdata2 = '0;
    end else if (wb_wreg && (raddr2 == wb_wd)) begin
      rdata2 = wb_wdata;
    end else begin
      rdata2 = regs_q[raddr2];
    end
  end

  // HI and LO share one select so they can never diverge.
  always_comb begin
    hi_o = hi_q;
    lo_o = lo_q;
    if (rst) begin
      hi_o = '0;
      lo_o = '0;
    end else if (wb_whilo) begin
      hi_o = wb_hi;
      lo_o = wb_lo;
    end
  end

endmodule

// File: tb/tb_wb_regfile_hilo.sv
// Scoreboard bench for wb_regfile_hilo: driver pushes expected reads,
// monitor pops and compares at the falling edge.
module tb_wb_regfile_hilo;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_wreg;
  logic [4:0]  wb_wd;
  logic [31:0] wb_wdata;
  logic        wb_whilo;
  logic [31:0] wb_hi;
  logic [31:0] wb_lo;
  logic        re1;
  logic [4:0]  raddr1;
  logic [31:0] rdata1;
  logic        re2;
  logic [4:0]  raddr2;
  logic [31:0] rdata2;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  wb_regfile_hilo dut (
    .clk      (clk),
    .rst      (rst),
    .wb_wreg  (wb_wreg),
    .wb_wd    (wb_wd),
    .wb_wdata (wb_wdata),
    .wb_whilo (wb_whilo),
    .wb_hi    (wb_hi),
    .wb_lo    (wb_lo),
    .re1      (re1),
    .raddr1   (raddr1),
    .rdata1   (rdata1),
    .re2      (re2),
    .raddr2   (raddr2),
    .rdata2   (rdata2),
    .hi_o     (hi_o),
    .lo_o     (lo_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q [$];

  int checks = 0;
  int errors = 0;

  // Reference: architectural state after the last committed edge.
  logic [31:0] m_regs [32];
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  function automatic logic [31:0] m_read(
    input logic r, input logic en, input logic [4:0] a,
    input logic we, input logic [4:0] wd, input logic [31:0] wdat);
    if (r || !en || a == 5'd0) return 32'h0;
    if (we && a == wd) return wdat;
    return m_regs[a];
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step(
    input string tag,
    input logic r, input logic we, input logic [4:0] wd,
    input logic [31:0] wdat, input logic wh,
    input logic [31:0] h, input logic [31:0] l,
    input logic e1, input logic [4:0] a1,
    input logic e2, input logic [4:0] a2);
    exp_t e;
    @(posedge clk);
    #2;
    rst = r; wb_wreg = we; wb_wd = wd; wb_wdata = wdat;
    wb_whilo = wh; wb_hi = h; wb_lo = l;
    re1 = e1; raddr1 = a1; re2 = e2; raddr2 = a2;
    e.tag = tag;
    e.r1 = m_read(r, e1, a1, we, wd, wdat);
    e.r2 = m_read(r, e2, a2, we, wd, wdat);
    e.hi = r ? 32'h0 : (wh ? h : m_hi);
    e.lo = r ? 32'h0 : (wh ? l : m_lo);
    exp_q.push_back(e);
    if (r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_hi = 32'h0;
      m_lo = 32'h0;
    end else begin
      if (we && wd != 5'd0) m_regs[wd] = wdat;
      if (wh) begin
        m_hi = h;
        m_lo = l;
      end
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk({e.tag, ".rdata1"}, rdata1, e.r1);
        chk({e.tag, ".rdata2"}, rdata2, e.r2);
        chk({e.tag, ".hi_o"}, hi_o, e.hi);
        chk({e.tag, ".lo_o"}, lo_o, e.lo);
      end
    end
  end

  initial begin : driver
    int wait_cyc;
    logic [4:0] a1, a2, wd;
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_hi = 32'h0;
    m_lo = 32'h0;
    rst = 1'b1; wb_wreg = 1'b0; wb_wd = '0; wb_wdata = '0;
    wb_whilo = 1'b0; wb_hi = '0; wb_lo = '0;
    re1 = 1'b0; raddr1 = '0; re2 = 1'b0; raddr2 = '0;

    step("rst0", 1, 0, 0, 0, 0, 0, 0, 1, 5, 1, 6);
    step("rst1", 1, 1, 5, 32'h77, 1, 32'h3, 32'h4, 1, 5, 1, 5);
    // Preload then reset mid-operation.
    step("pre", 0, 1, 5, 32'hDEADBEEF, 1, 32'h1, 32'h2, 0, 0, 0, 0);
    step("prechk", 0, 0, 0, 0, 0, 0, 0, 1, 5, 1, 5);
    step("rstmid", 1, 0, 0, 0, 0, 0, 0, 1, 5, 1, 5);
    step("postrst", 0, 0, 0, 0, 0, 0, 0, 1, 5, 1, 5);
    // Plain write then read.
    step("wr7", 0, 1, 7, 32'h12345678, 0, 0, 0, 0, 0, 0, 0);
    step("rd7", 0, 0, 0, 0, 0, 0, 0, 1, 7, 1, 7);
    // Same-cycle bypass on both ports.
    step("wr9", 0, 1, 9, 32'h1, 0, 0, 0, 0, 0, 0, 0);
    step("byp9", 0, 1, 9, 32'hAAAA5555, 0, 0, 0, 1, 9, 1, 9);
    step("rd9", 0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 9);
    // $0 and read enable.
    step("wr0", 0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 1, 0, 0, 7);
    step("rd0", 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 7);
    // HI/LO bypass then hold.
    step("hilo", 0, 0, 0, 0, 1, 32'h11, 32'h22, 0, 0, 0, 0);
    step("hilo_keep", 0, 0, 0, 0, 0, 32'h33, 32'h44, 0, 0, 0, 0);
    step("both", 0, 1, 12, 32'hC0FFEE, 1, 32'h55, 32'h66, 1, 12, 1, 7);
    // Reset collides with a pending write.
    step("rstcol", 1, 1, 3, 32'h55, 1, 32'h9, 32'h9, 1, 3, 1, 3);
    step("rd3", 0, 0, 0, 0, 0, 0, 0, 1, 3, 1, 12);

    for (int n = 0; n < 400; n++) begin
      a1 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      a2 = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      wd = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom);
      step("rnd", ($urandom_range(0, 39) == 0), 1'($urandom), wd, $urandom,
           ($urandom_range(0, 2) == 0), $urandom, $urandom,
           ($urandom_range(0, 7) != 0), a1, ($urandom_range(0, 7) != 0), a2);
    end

    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d left expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
